// File: rtl/alu_pkg.sv
// Shared types for the 16-bit ALU and the alu_arbiter sequencer.
package alu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ENC = 2'd2,
        OP_DEC = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU: ADD/SUB mod 2^16, ENC/DEC byte-chained XOR code.
module alu
    import alu_pkg::*;
(
    input  opcode_t             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   y
);

    localparam int H = DATA_W / 2;

    logic [H-1:0] lo;
    logic         unused_b_hi;

    // Only the low byte of b acts as the key; DEC undoes ENC with the same key.
    assign unused_b_hi = ^b[DATA_W-1:H];

    always_comb begin
        lo = a[H-1:0] ^ b[H-1:0];
        y  = '0;
        unique case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_ENC:  y = {a[DATA_W-1:H] ^ lo, lo};
            OP_DEC:  y = {a[DATA_W-1:H] ^ a[H-1:0], lo};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic               any_valid,
    output logic [ID_W-1:0]    grant
);

    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any_valid && valid[(int'(last_grant) + k) % NUM_REQ]) begin
                any_valid = 1'b1;
                grant     = ID_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: accept (IDLE) -> compute (EXEC) -> respond (RESP).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_instr,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic [DATA_W-1:0]         op_count
);

    state_t              state, state_next;
    logic [ID_W-1:0]     last_grant, grant, cur_id;
    logic                any_valid;
    opcode_t             cur_op;
    logic [DATA_W-1:0]   cur_a, cur_b, alu_y, count_q;
    logic                accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .any_valid  (any_valid),
        .grant      (grant)
    );

    // The ALU only ever sees latched operands, never the live request buses.
    alu u_alu (
        .op (cur_op),
        .a  (cur_a),
        .b  (cur_b),
        .y  (alu_y)
    );

    assign accept   = (state == ST_IDLE) && any_valid;
    assign busy     = (state != ST_IDLE);
    assign op_count = count_q;

    always_comb begin
        state_next = state;
        req_ready  = '0;
        unique case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    req_ready[grant] = 1'b1;
                    state_next       = ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            cur_id     <= '0;
            cur_op     <= OP_ADD;
            cur_a      <= '0;
            cur_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            count_q    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= grant;
                cur_id     <= grant;
                cur_op     <= opcode_t'(req_instr[2*grant +: 2]);
                cur_a      <= req_a[DATA_W*grant +: DATA_W];
                cur_b      <= req_b[DATA_W*grant +: DATA_W];
            end
            if (state == ST_EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= cur_id;
                rsp_data  <= alu_y;
            end
            // rsp_id/rsp_data keep their last value after the handshake.
            if (state == ST_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                count_q   <= count_q + 1'b1;
            end
        end
    end

endmodule
